oam_dma_engine: RTL and testbench

OAM_DMA_ENGINE -- requirements
Module: oam_dma_engine

---
 rtl/oam_dma_engine.sv | 108 ++++++++++
 tb/tb_oam_dma_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies XFER_LEN bytes from page {dma_page,00} to DEST_BASE,
// one byte every two cycles (READ then WRITE), locking the CPU out via busy.
module oam_dma_engine #(
    parameter int unsigned XFER_LEN  = 160,
    parameter logic [15:0] DEST_BASE = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  mem_wdata,
    output logic        mem_oe,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state;
    logic [7:0] src_page;
    logic [7:0] idx;
    logic [7:0] data_q;

    // The byte captured during READ is what gets driven during WRITE.
    assign mem_wdata = data_q;

    // Sequencer: state, byte index and all memory-side outputs are registered
    // together so each output reflects the state it is presented in.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            src_page <= 8'h00;
            idx      <= 8'h00;
            data_q   <= 8'h00;
            mem_addr <= 16'h0000;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            mem_oe   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (dma_start) begin
                // A start in any state (re)begins from byte 0 of the new page;
                // a WRITE already on the bus this cycle still lands, and an
                // aborted transfer never reports done.
                state    <= READ;
                src_page <= dma_page;
                idx      <= 8'h00;
                mem_addr <= {dma_page, 8'h00};
                mem_re   <= 1'b1;
                mem_we   <= 1'b0;
                mem_oe   <= 1'b0;
                busy     <= 1'b1;
            end else begin
                case (state)
                    READ: begin
                        data_q   <= mem_rdata;
                        state    <= WRITE;
                        mem_addr <= DEST_BASE + {8'h00, idx};
                        mem_re   <= 1'b0;
                        mem_we   <= 1'b1;
                        mem_oe   <= 1'b1;
                        busy     <= 1'b1;
                    end
                    WRITE: begin
                        if (idx == LAST_IDX) begin
                            state    <= IDLE;
                            done     <= 1'b1;
                            mem_addr <= 16'h0000;
                            mem_re   <= 1'b0;
                            mem_we   <= 1'b0;
                            mem_oe   <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            idx      <= idx + 8'd1;
                            state    <= READ;
                            mem_addr <= {src_page, idx + 8'd1};
                            mem_re   <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_oe   <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        mem_addr <= 16'h0000;
                        mem_re   <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_oe   <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Testbench for oam_dma_engine: a 64 KiB memory model per DUT instance, a
// cycle-level expectation derived from "odd cycle reads byte i, even cycle
// writes byte i", and randomized page contents and restart points.
module tb_oam_dma_engine;

    localparam int          LEN0 = 160;
    localparam logic [15:0] DEST = 16'hFE00;

    logic        clk   = 1'b0;
    logic        rst_b = 1'b0;

    logic        dma_start = 1'b0;
    logic [7:0]  dma_page  = 8'h00;
    logic [15:0] mem_addr0;
    logic        mem_re0, mem_we0, mem_oe0, busy0, done0;
    logic [7:0]  mem_rdata0, mem_wdata0;

    logic        start1 = 1'b0;
    logic [7:0]  page1  = 8'h00;
    logic [15:0] mem_addr1;
    logic        mem_re1, mem_we1, mem_oe1, busy1, done1;
    logic [7:0]  mem_rdata1, mem_wdata1;

    logic [7:0]  mem0 [0:65535];
    logic [7:0]  mem1 [0:65535];
    logic [7:0]  dstSnap [0:255];

    logic        fillReq     = 1'b0;
    logic        fillPattern = 1'b0;
    logic [7:0]  fillPg      = 8'h00;

    int checkCount = 0;
    int errorCount = 0;

    oam_dma_engine #(.XFER_LEN(LEN0), .DEST_BASE(DEST)) dut (
        .clk(clk), .rst_b(rst_b), .dma_start(dma_start), .dma_page(dma_page),
        .mem_addr(mem_addr0), .mem_re(mem_re0), .mem_we(mem_we0),
        .mem_rdata(mem_rdata0), .mem_wdata(mem_wdata0), .mem_oe(mem_oe0),
        .busy(busy0), .done(done0)
    );

    oam_dma_engine #(.XFER_LEN(1), .DEST_BASE(DEST)) dutOne (
        .clk(clk), .rst_b(rst_b), .dma_start(start1), .dma_page(page1),
        .mem_addr(mem_addr1), .mem_re(mem_re1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1), .mem_wdata(mem_wdata1), .mem_oe(mem_oe1),
        .busy(busy1), .done(done1)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Combinational read port of each memory model.
    assign mem_rdata0 = mem_re0 ? mem0[mem_addr0] : 8'h00;
    assign mem_rdata1 = mem_re1 ? mem1[mem_addr1] : 8'h00;

    // Memory writes from the DUTs plus whole-page fills requested by the bench.
    always @(posedge clk) begin
        if (mem_we0 && mem_oe0) mem0[mem_addr0] = mem_wdata0;
        if (mem_we1 && mem_oe1) mem1[mem_addr1] = mem_wdata1;
        if (fillReq) begin
            for (int i = 0; i < 256; i++) begin
                mem0[{fillPg, 8'(i)}] = fillPattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
                mem1[{fillPg, 8'(i)}] = mem0[{fillPg, 8'(i)}];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic fillPage(input logic [7:0] pg, input logic pattern);
        fillPg      = pg;
        fillPattern = pattern;
        fillReq     = 1'b1;
        @(negedge clk);
        fillReq     = 1'b0;
    endtask

    task automatic takeSnap();
        for (int i = 0; i < 256; i++) dstSnap[i] = mem0[DEST + 16'(i)];
    endtask

    // Pulse dma_start for one cycle; returns at the negedge of cycle 1.
    task automatic applyStimulus(input logic [7:0] pg);
        dma_start = 1'b1;
        dma_page  = pg;
        @(negedge clk);
        dma_start = 1'b0;
        dma_page  = $urandom;
    endtask

    // Follow one full transfer from cycle 1 through the done cycle.
    task automatic monitorTransfer(input logic [7:0] pg, input logic chain,
                                   input logic [7:0] nextPg);
        logic [15:0] expAddr;
        logic [4:0]  expCtrl;
        int          i;
        for (int k = 1; k <= 2 * LEN0 + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 2 * LEN0) begin
                if (k % 2 == 1) begin
                    i       = (k - 1) / 2;
                    expAddr = {pg, 8'(i)};
                    expCtrl = 5'b10010;
                end else begin
                    i       = k / 2 - 1;
                    expAddr = DEST + 16'(i);
                    expCtrl = 5'b01110;
                    checkOutput("wdata", 32'(mem_wdata0), 32'(mem0[{pg, 8'(i)}]));
                end
            end else begin
                expAddr = 16'h0000;
                expCtrl = 5'b00001;
            end
            checkOutput("addr", 32'(mem_addr0), 32'(expAddr));
            checkOutput("re_we_oe_busy_done",
                        32'({mem_re0, mem_we0, mem_oe0, busy0, done0}), 32'(expCtrl));
        end
        if (chain) begin
            applyStimulus(nextPg);
        end else begin
            @(negedge clk);
            checkOutput("done_single_pulse", 32'({busy0, done0}), 32'h0);
        end
    endtask

    // Destination holds the source page bytes and nothing past the range moved.
    task automatic checkDest(input logic [7:0] pg);
        for (int i = 0; i < 256; i++) begin
            if (i < LEN0)
                checkOutput("dest_copy", 32'(mem0[DEST + 16'(i)]), 32'(mem0[{pg, 8'(i)}]));
            else
                checkOutput("dest_untouched", 32'(mem0[DEST + 16'(i)]), 32'(dstSnap[i]));
        end
    endtask

    task automatic doTransfer(input logic [7:0] pg, input logic pattern);
        fillPage(pg, pattern);
        fillPage(8'hFE, 1'b0);
        takeSnap();
        applyStimulus(pg);
        monitorTransfer(pg, 1'b0, 8'h00);
        checkDest(pg);
    endtask

    task automatic doRestart(input logic [7:0] p1, input logic [7:0] p2, input int offset);
        int j;
        fillPage(p1, 1'b0);
        fillPage(p2, 1'b0);
        fillPage(8'hFE, 1'b0);
        takeSnap();
        applyStimulus(p1);
        for (int k = 1; k <= offset; k++) begin
            if (k > 1) @(negedge clk);
            checkOutput("pre_restart_busy_done", 32'({busy0, done0}), 32'h2);
        end
        applyStimulus(p2);
        if (offset % 2 == 0) begin
            j = offset / 2 - 1;
            checkOutput("inflight_write", 32'(mem0[DEST + 16'(j)]), 32'(mem0[{p1, 8'(j)}]));
        end
        monitorTransfer(p2, 1'b0, 8'h00);
        checkDest(p2);
    endtask

    initial begin
        logic [7:0] pg;
        logic [7:0] pgB;
        logic [7:0] snapOne;
        int         off;

        // Reset state, held asynchronously from time zero.
        @(negedge clk);
        checkOutput("reset_addr", 32'(mem_addr0), 32'h0);
        checkOutput("reset_ctrl", 32'({mem_re0, mem_we0, mem_oe0, busy0, done0}), 32'h0);
        checkOutput("reset_wdata", 32'(mem_wdata0), 32'h0);
        checkOutput("reset_one_ctrl", 32'({mem_re1, mem_we1, mem_oe1, busy1, done1}), 32'h0);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_reset", 32'({mem_addr0, mem_re0, mem_we0, mem_oe0, busy0, done0}), 32'h0);

        // Single-byte instance: READ, WRITE, then done.
        pg = 8'($urandom_range(253, 0));
        fillPage(pg, 1'b0);
        fillPage(8'hFE, 1'b0);
        snapOne = mem1[16'hFE01];
        start1 = 1'b1;
        page1  = pg;
        @(negedge clk);
        start1 = 1'b0;
        checkOutput("len1_c1_addr", 32'(mem_addr1), 32'({pg, 8'h00}));
        checkOutput("len1_c1_ctrl", 32'({mem_re1, mem_we1, mem_oe1, busy1, done1}), 32'h12);
        @(negedge clk);
        checkOutput("len1_c2_addr", 32'(mem_addr1), 32'(DEST));
        checkOutput("len1_c2_ctrl", 32'({mem_re1, mem_we1, mem_oe1, busy1, done1}), 32'h0E);
        checkOutput("len1_c2_wdata", 32'(mem_wdata1), 32'(mem1[{pg, 8'h00}]));
        @(negedge clk);
        checkOutput("len1_c3_ctrl", 32'({mem_re1, mem_we1, mem_oe1, busy1, done1}), 32'h01);
        @(negedge clk);
        checkOutput("len1_c4_ctrl", 32'({mem_re1, mem_we1, mem_oe1, busy1, done1}), 32'h00);
        checkOutput("len1_dest", 32'(mem1[DEST]), 32'(mem1[{pg, 8'h00}]));
        checkOutput("len1_next_untouched", 32'(mem1[16'hFE01]), 32'(snapOne));

        // Basic copy from C0 with the i^5A pattern, then random pages, then FF.
        doTransfer(8'hC0, 1'b1);
        for (int n = 0; n < 3; n++) doTransfer(8'($urandom_range(253, 0)), 1'b0);
        doTransfer(8'hFF, 1'b0);

        // Restart during a WRITE (cycle 50) and during a random READ.
        doRestart(8'hC0, 8'hD0, 50);
        off = 2 * int'($urandom_range(150, 1)) + 1;
        doRestart(8'($urandom_range(253, 0)), 8'($urandom_range(253, 0)), off);

        // Start arriving in the done cycle chains straight into a new transfer.
        pg  = 8'($urandom_range(127, 0));
        pgB = 8'($urandom_range(253, 128));
        fillPage(pg, 1'b0);
        fillPage(pgB, 1'b0);
        fillPage(8'hFE, 1'b0);
        takeSnap();
        applyStimulus(pg);
        monitorTransfer(pg, 1'b1, pgB);
        monitorTransfer(pgB, 1'b0, 8'h00);
        checkDest(pgB);

        // Reset in cycle 101 kills the transfer before byte 0x32 is written.
        fillPage(8'hC0, 1'b1);
        fillPage(8'hFE, 1'b0);
        takeSnap();
        applyStimulus(8'hC0);
        repeat (100) @(negedge clk);
        rst_b = 1'b0;
        #1;
        checkOutput("midreset_addr", 32'(mem_addr0), 32'h0);
        checkOutput("midreset_ctrl", 32'({mem_re0, mem_we0, mem_oe0, busy0, done0}), 32'h0);
        checkOutput("midreset_wdata", 32'(mem_wdata0), 32'h0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < LEN0; i++) begin
            if (i < 8'h32)
                checkOutput("midreset_written", 32'(mem0[DEST + 16'(i)]), 32'(8'(i) ^ 8'h5A));
            else
                checkOutput("midreset_unchanged", 32'(mem0[DEST + 16'(i)]), 32'(dstSnap[i]));
        end
        rst_b = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("idle_after_midreset",
                    32'({mem_addr0, mem_re0, mem_we0, mem_oe0, busy0, done0}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
